// File: rtl/pc_update.sv
// Y86-64 program counter, architectural status and retired-instruction counter.
// Selects the next PC from fetch/execute results and freezes once the core leaves AOK.
module pc_update #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valP_i,
  input  logic [63:0] valM_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  output logic [63:0] PC_o,
  output logic [2:0]  stat_o,
  output logic        halted_o,
  output logic [63:0] retired_o
);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  stat_e       stat_q, stat_d;
  stat_e       instr_stat;
  logic [63:0] pc_q, pc_d;
  logic [63:0] retired_q, retired_d;
  logic [63:0] new_pc;

  // Fetch address faults outrank decode faults, which outrank data faults.
  always_comb begin
    instr_stat = STAT_AOK;
    if (imem_error_i)            instr_stat = STAT_ADR;
    else if (!instr_valid_i)     instr_stat = STAT_INS;
    else if (dmem_error_i)       instr_stat = STAT_ADR;
    else if (icode_i == I_HALT)  instr_stat = STAT_HLT;
  end

  always_comb begin
    new_pc = valP_i;
    if (icode_i == I_CALL)                new_pc = valC_i;
    else if (icode_i == I_JXX && cnd_i)   new_pc = valC_i;
    else if (icode_i == I_RET)            new_pc = valM_i;
  end

  always_comb begin
    stat_d    = stat_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    if (stat_q == STAT_AOK && en_i) begin
      case (instr_stat)
        STAT_AOK: begin
          pc_d      = new_pc;
          retired_d = retired_q + 64'd1;
        end
        STAT_HLT: begin
          // HALT retires but leaves the PC on the halting instruction.
          stat_d    = STAT_HLT;
          retired_d = retired_q + 64'd1;
        end
        default: stat_d = instr_stat;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q    <= STAT_AOK;
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      stat_q    <= stat_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign PC_o      = pc_q;
  assign stat_o    = stat_q;
  assign halted_o  = (stat_q != STAT_AOK);
  assign retired_o = retired_q;

endmodule
